// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port among NUM_REQ requesters, with
// per-requester locking for atomic read-modify-write and a stale-lock timeout.
module mem_port_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int SIZE         = 16,
  parameter int WIDTH        = 128,
  parameter int LOCK_TIMEOUT = 16,
  localparam int ADDR_W      = $clog2(SIZE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]  req_din,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [WIDTH-1:0]          rsp_data,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [WIDTH-1:0]          mem_din,
  input  logic [WIDTH-1:0]          mem_dout
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

  // Handshake: an access happens on a rising edge where req_valid[i] & req_ready[i];
  // req_ready is combinational, one-hot or zero, and never depends on rsp sinking.
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rrPtr;
  logic [IDX_W-1:0]   lockOwner;
  logic [CNT_W-1:0]   idleCnt;
  logic               lockBroken;
  logic [NUM_REQ-1:0] rspValid;

  logic               grantHit;
  logic [IDX_W-1:0]   grantIdx;
  logic [IDX_W-1:0]   candIdx;
  logic [IDX_W-1:0]   nextPtr;

  logic [ADDR_W-1:0]  addrArr [NUM_REQ];
  logic [WIDTH-1:0]   dinArr  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
    assign addrArr[i] = req_addr[i*ADDR_W +: ADDR_W];
    assign dinArr[i]  = req_din[i*WIDTH +: WIDTH];
  end

  always_comb begin
    grantHit = 1'b0;
    grantIdx = '0;
    candIdx  = '0;
    if (state == LOCKED) begin
      grantHit = req_valid[lockOwner];
      grantIdx = lockOwner;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        candIdx = IDX_W'((int'(rrPtr) + k) % NUM_REQ);
        if (!grantHit && req_valid[candIdx]) begin
          grantHit = 1'b1;
          grantIdx = candIdx;
        end
      end
    end
    // Nothing is accepted while reset is held, so no response can leak out of it.
    if (rst) grantHit = 1'b0;
  end

  assign nextPtr   = (grantIdx == IDX_W'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
  assign req_ready = grantHit ? (NUM_REQ'(1) << grantIdx) : '0;
  assign mem_en    = grantHit;
  assign mem_we    = grantHit & req_we[grantIdx];
  assign mem_addr  = addrArr[grantIdx];
  assign mem_din   = dinArr[grantIdx];
  assign rsp_valid = rspValid;
  assign rsp_data  = mem_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= UNLOCKED;
      rrPtr      <= '0;
      lockOwner  <= '0;
      idleCnt    <= '0;
      lockBroken <= 1'b0;
      rspValid   <= '0;
    end else begin
      rspValid <= '0;
      if (grantHit && !req_we[grantIdx]) rspValid[grantIdx] <= 1'b1;
      case (state)
        UNLOCKED: begin
          idleCnt <= '0;
          if (grantHit) begin
            if (req_lock[grantIdx]) begin
              state     <= LOCKED;
              lockOwner <= grantIdx;
            end else begin
              rrPtr <= nextPtr;
            end
          end
        end
        LOCKED: begin
          if (grantHit) begin
            idleCnt <= '0;
            if (!req_lock[grantIdx]) begin
              state <= UNLOCKED;
              rrPtr <= nextPtr;
            end
          end else if (idleCnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
            // Owner went quiet too long: drop the lock, keep rrPtr where it was.
            state      <= UNLOCKED;
            idleCnt    <= '0;
            lockBroken <= lockBroken | 1'b1;
          end else begin
            idleCnt <= idleCnt + 1'b1;
          end
        end
        default: state <= UNLOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: driver pushes expected grants/responses,
// a negedge monitor pops and compares them against the DUT.
module tb_mem_port_arbiter;

  localparam int NUM_REQ = 4;
  localparam int SIZE    = 16;
  localparam int WIDTH   = 128;
  localparam int ADDR_W  = 4;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0]  req_din;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [WIDTH-1:0]          rsp_data;
  logic                      mem_en;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [WIDTH-1:0]          mem_din;
  logic [WIDTH-1:0]          mem_dout;

  mem_port_arbiter #(
    .NUM_REQ(NUM_REQ), .SIZE(SIZE), .WIDTH(WIDTH), .LOCK_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_lock(req_lock), .req_addr(req_addr), .req_din(req_din),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [15:0] cyc;
  initial cyc = '0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  function automatic logic [WIDTH-1:0] pat(input int a);
    logic [15:0] w;
    w = 16'hB000 + 16'(a);
    return {8{w}};
  endfunction

  // BRAM stand-in: registered READ_FIRST port, preloaded with pat(addr) on reset
  logic [WIDTH-1:0] mem [SIZE];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) mem[i] <= pat(i);
    end else if (mem_en) begin
      mem_dout <= mem[mem_addr];
      if (mem_we) mem[mem_addr] <= mem_din;
    end
  end

  // scoreboard queues
  logic [9:0]   exp_q[$];
  logic [147:0] exp_rsp_q[$];
  int           errors;
  int           checks;
  logic         done;

  task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] we,
                       input logic [3:0] lk, input logic [15:0] a, input logic [WIDTH-1:0] d,
                       input logic [3:0] er, input logic ew, input logic [3:0] ea);
    @(posedge clk);
    #1;
    rst       = r;
    req_valid = v;
    req_we    = we;
    req_lock  = lk;
    req_addr  = a;
    req_din   = {4{d}};
    exp_q.push_back({er, |er, ew, ea});
  endtask

  task automatic push_rsp(input int req, input logic [WIDTH-1:0] d);
    logic [3:0] oh;
    oh = 4'b0001 << req;
    exp_rsp_q.push_back({cyc + 16'd1, oh, d});
  endtask

  // monitor
  always @(negedge clk) begin
    logic [9:0]   eg, gg;
    logic [147:0] er;
    if (exp_q.size() > 0) begin
      eg = exp_q.pop_front();
      gg = {req_ready, mem_en, mem_en & mem_we, mem_en ? mem_addr : 4'h0};
      checks++;
      if (gg !== eg) begin
        errors++;
        $display("FAIL grant cyc=%0d got ready=%b en=%b we=%b addr=%h exp ready=%b en=%b we=%b addr=%h",
                 cyc, gg[9:6], gg[5], gg[4], gg[3:0], eg[9:6], eg[5], eg[4], eg[3:0]);
      end
    end
    if (rsp_valid !== 4'b0000) begin
      checks++;
      if (exp_rsp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected cyc=%0d got rsp_valid=%b exp none", cyc, rsp_valid);
      end else begin
        er = exp_rsp_q.pop_front();
        if ({cyc, rsp_valid, rsp_data} !== er) begin
          errors++;
          $display("FAIL rsp cyc=%0d got valid=%b data=%h exp cyc=%0d valid=%b data=%h",
                   cyc, rsp_valid, rsp_data, er[147:132], er[131:128], er[127:0]);
        end
      end
    end else if (exp_rsp_q.size() > 0 && exp_rsp_q[0][147:132] == cyc) begin
      er = exp_rsp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL rsp_missing cyc=%0d got valid=0000 exp valid=%b", cyc, er[131:128]);
    end
    if (done) begin
      checks++;
      if (exp_q.size() != 0 || exp_rsp_q.size() != 0) begin
        errors++;
        $display("FAIL drain got grants_left=%0d rsps_left=%0d exp 0/0", exp_q.size(), exp_rsp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  localparam logic [WIDTH-1:0] A5 = {16{8'hA5}};
  localparam logic [WIDTH-1:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  initial begin
    errors = 0; checks = 0; done = 1'b0;
    rst = 1'b1; req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_din = '0;

    // reset: ready forced low even with requests present
    drive(1, 4'hF, 4'h0, 4'h0, 16'h4321, '0, 4'h0, 0, 4'h0);
    drive(1, 4'h0, 4'h0, 4'h0, 16'h4321, '0, 4'h0, 0, 4'h0);

    // fairness: all four read continuously
    for (int i = 0; i < 6; i++) begin
      drive(0, 4'hF, 4'h0, 4'h0, 16'h4321, '0, 4'(1 << (i % 4)), 0, 4'((i % 4) + 1));
      push_rsp(i % 4, pat((i % 4) + 1));
    end

    // write then read-after-write
    drive(0, 4'b0010, 4'b0010, 4'h0, 16'h0030, A5, 4'b0010, 1, 4'd3);
    drive(0, 4'b0100, 4'h0, 4'h0, 16'h0300, '0, 4'b0100, 0, 4'd3);
    push_rsp(2, A5);
    drive(0, 4'b0010, 4'h0, 4'h0, 16'h0070, '0, 4'b0010, 0, 4'd7);
    push_rsp(1, pat(7));

    // lock / read-modify-write by req2 with everyone else contending
    drive(0, 4'hF, 4'h0, 4'b0100, 16'h0500, '0, 4'b0100, 0, 4'd5);
    push_rsp(2, pat(5));
    drive(0, 4'hF, 4'b0100, 4'h0, 16'h0500, D1, 4'b0100, 1, 4'd5);
    drive(0, 4'hF, 4'h0, 4'h0, 16'h0500, '0, 4'b1000, 0, 4'd0);
    push_rsp(3, pat(0));
    drive(0, 4'b1000, 4'h0, 4'h0, 16'h5000, '0, 4'b1000, 0, 4'd5);
    push_rsp(3, D1);

    // lock timeout: req1 locks then goes quiet
    drive(0, 4'b0010, 4'h0, 4'b0010, 16'h0060, '0, 4'b0010, 0, 4'd6);
    push_rsp(1, pat(6));
    for (int i = 0; i < 4; i++)
      drive(0, 4'b0101, 4'h0, 4'h0, 16'h0802, '0, 4'h0, 0, 4'h0);
    drive(0, 4'b0101, 4'h0, 4'h0, 16'h0802, '0, 4'b0001, 0, 4'd2);
    push_rsp(0, pat(2));

    // reset while req3 holds the lock
    drive(0, 4'b1000, 4'h0, 4'b1000, 16'h9000, '0, 4'b1000, 0, 4'd9);
    push_rsp(3, pat(9));
    drive(1, 4'b1000, 4'h0, 4'b1000, 16'h9000, '0, 4'h0, 0, 4'h0);
    drive(0, 4'b1001, 4'h0, 4'h0, 16'h9001, '0, 4'b0001, 0, 4'd1);
    push_rsp(0, pat(1));

    // sparse requesters with pointer wrap
    drive(0, 4'b0100, 4'h0, 4'h0, 16'h0A00, '0, 4'b0100, 0, 4'd10);
    push_rsp(2, pat(10));
    for (int r = 0; r < 2; r++) begin
      drive(0, 4'b1001, 4'h0, 4'h0, 16'hB00C, '0, 4'b1000, 0, 4'd11);
      push_rsp(3, pat(11));
      drive(0, 4'b1001, 4'h0, 4'h0, 16'hB00C, '0, 4'b0001, 0, 4'd12);
      push_rsp(0, pat(12));
      drive(0, 4'h0, 4'h0, 4'h0, 16'hB00C, '0, 4'h0, 0, 4'h0);
    end
    drive(0, 4'h0, 4'h0, 4'h0, 16'h0000, '0, 4'h0, 0, 4'h0);

    @(posedge clk);
    #1 done = 1'b1;
  end

endmodule
